// File: rtl/one_hot_pkg.sv
// Shared types and helpers for the one-hot decoder: default widths, word
// classification and lowest-set-bit search usable by any one-hot consumer.
package one_hot_pkg;

  localparam int unsigned DEF_BIN_W     = 4;
  localparam int unsigned DEF_ONE_HOT_W = 16;
  localparam int unsigned DEF_ERR_CNT_W = 8;

  // Helpers take a zero-extended word so one definition serves every width.
  localparam int unsigned OH_MAX_W = 256;

  typedef enum logic [1:0] {
    OH_ZERO,
    OH_ONE,
    OH_MULTI
  } oh_class_e;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  function automatic int lowest_set_idx(input logic [OH_MAX_W-1:0] word);
    int idx;
    idx = 0;
    for (int i = OH_MAX_W - 1; i >= 0; i--) begin
      if (word[i]) idx = i;
    end
    return idx;
  endfunction

  // Zero / one / many detection only; a full popcount is never needed.
  function automatic oh_class_e onehot_class(input logic [OH_MAX_W-1:0] word);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      multi = multi | (seen & word[i]);
      seen  = seen | word[i];
    end
    if (!seen) return OH_ZERO;
    if (multi) return OH_MULTI;
    return OH_ONE;
  endfunction

endpackage

// File: rtl/one_hot_chk.sv
// Combinational one-hot checker: lowest set bit index plus a flag raised
// when the word does not have exactly one bit set.
module one_hot_chk
  import one_hot_pkg::*;
#(
  parameter int unsigned BIN_W     = DEF_BIN_W,
  parameter int unsigned ONE_HOT_W = DEF_ONE_HOT_W
) (
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic [BIN_W-1:0]     idx_o,
  output logic                 err_o
);

  if (ONE_HOT_W > OH_MAX_W) begin : g_width_chk
    $error("one_hot_chk: ONE_HOT_W exceeds helper width OH_MAX_W");
  end

  logic [OH_MAX_W-1:0] word_ext;
  oh_class_e           word_cls;

  always_comb begin
    word_ext = OH_MAX_W'(one_hot_i);
    word_cls = onehot_class(word_ext);
    idx_o    = BIN_W'(lowest_set_idx(word_ext));
    err_o    = (word_cls != OH_ONE);
  end

endmodule

// File: rtl/one_hot_dec.sv
// Streaming one-hot to binary decoder with a single full-throughput output
// register and a saturating count of malformed words.
module one_hot_dec
  import one_hot_pkg::*;
#(
  parameter int unsigned BIN_W     = DEF_BIN_W,
  parameter int unsigned ONE_HOT_W = DEF_ONE_HOT_W,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 clr_cnt_i
);

  if (ONE_HOT_W != 2 ** BIN_W) begin : g_param_chk
    $error("one_hot_dec: ONE_HOT_W must equal 2**BIN_W");
  end

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic [BIN_W-1:0]     chk_idx;
  logic                 chk_err;
  logic                 accept;
  logic                 xfer;

  one_hot_chk #(
    .BIN_W    (BIN_W),
    .ONE_HOT_W(ONE_HOT_W)
  ) u_chk (
    .one_hot_i(one_hot_i),
    .idx_o    (chk_idx),
    .err_o    (chk_err)
  );

  assign valid_o   = (state_q == ST_FULL);
  assign ready_o   = !valid_o || ready_i;
  assign accept    = valid_i && ready_o;
  assign xfer      = valid_o && ready_i;
  assign bin_o     = bin_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

  always_comb begin
    // NOTE: every signal gets a hold value first so no path infers a latch.
    state_d = state_q;
    bin_d   = bin_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_EMPTY: if (accept)          state_d = ST_FULL;
      ST_FULL:  if (xfer && !accept) state_d = ST_EMPTY;
      default:                       state_d = ST_EMPTY;
    endcase

    // Checker outputs are only looked at on accept, so garbage on an idle
    // input never reaches state.
    if (accept) begin
      bin_d = chk_idx;
      err_d = chk_err;
    end

    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (accept && chk_err && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: the data register is reset too, so bin_o/err_o read zero out of
  // reset rather than whatever powered up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      bin_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values.
      state_q <= state_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_one_hot_dec.sv
// Directed self-checking bench for one_hot_dec: legal sweep, malformed words,
// backpressure, counter saturation/clear, async reset and encoded indices.
module tb_one_hot_dec;

  localparam int unsigned BIN_W     = 4;
  localparam int unsigned ONE_HOT_W = 16;
  localparam int unsigned ERR_CNT_W = 8;

  logic                 clk;
  logic                 reset_n;
  logic [ONE_HOT_W-1:0] one_hot_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [BIN_W-1:0]     bin_o;
  logic                 err_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [ERR_CNT_W-1:0] err_cnt_o;
  logic                 clr_cnt_i;

  int n_checks;
  int n_errs;

  one_hot_dec #(
    .BIN_W    (BIN_W),
    .ONE_HOT_W(ONE_HOT_W),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .one_hot_i(one_hot_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .bin_o    (bin_o),
    .err_o    (err_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .err_cnt_o(err_cnt_o),
    .clr_cnt_i(clr_cnt_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Stand-in for the upstream binary to one-hot encoder.
  function automatic logic [ONE_HOT_W-1:0] bin2oh(input int unsigned idx);
    logic [ONE_HOT_W-1:0] w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timed out");
  end

  initial begin
    int unsigned idx;
    n_checks  = 0;
    n_errs    = 0;
    reset_n   = 1'b0;
    one_hot_i = '0;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    clr_cnt_i = 1'b0;

    // Reset state
    #3;
    check("rst_valid", 32'(valid_o), 0);
    check("rst_bin", 32'(bin_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_cnt", 32'(err_cnt_o), 0);
    check("rst_ready", 32'(ready_o), 1);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();

    // 1. Legal sweep, back-to-back
    for (int k = 0; k < 16; k++) begin
      one_hot_i = bin2oh(k);
      valid_i   = 1'b1;
      check("sweep_ready", 32'(ready_o), 1);
      cyc();
      check("sweep_valid", 32'(valid_o), 1);
      check("sweep_bin", 32'(bin_o), 32'(k));
      check("sweep_err", 32'(err_o), 0);
    end
    check("sweep_cnt", 32'(err_cnt_o), 0);
    valid_i = 1'b0;
    cyc();
    check("drain_valid", 32'(valid_o), 0);

    // 2. Malformed words
    one_hot_i = 16'h0000;
    valid_i   = 1'b1;
    cyc();
    check("zero_bin", 32'(bin_o), 0);
    check("zero_err", 32'(err_o), 1);
    one_hot_i = 16'h0A00;
    cyc();
    check("multi_bin", 32'(bin_o), 9);
    check("multi_err", 32'(err_o), 1);
    check("malformed_cnt", 32'(err_cnt_o), 2);
    valid_i   = 1'b0;
    one_hot_i = 'x;
    cyc();
    check("idle_valid", 32'(valid_o), 0);
    check("idle_cnt", 32'(err_cnt_o), 2);

    // 3. Backpressure: a stalled second word must not be taken
    ready_i   = 1'b0;
    one_hot_i = 16'h0010;
    valid_i   = 1'b1;
    cyc();
    one_hot_i = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(valid_o), 1);
      check("bp_bin", 32'(bin_o), 4);
      check("bp_ready", 32'(ready_o), 0);
      cyc();
    end
    ready_i = 1'b1;
    #1;
    check("bp_release_ready", 32'(ready_o), 1);
    cyc();
    check("bp_next_valid", 32'(valid_o), 1);
    check("bp_next_bin", 32'(bin_o), 8);
    check("bp_next_err", 32'(err_o), 0);
    valid_i = 1'b0;
    cyc();
    check("bp_drain_valid", 32'(valid_o), 0);

    // 4. Saturation then clear (count starts at 2)
    one_hot_i = 16'h0003;
    valid_i   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (i == 251) check("sat_cnt_254", 32'(err_cnt_o), 254);
    end
    check("sat_cnt", 32'(err_cnt_o), 255);
    check("sat_bin", 32'(bin_o), 0);
    check("sat_err", 32'(err_o), 1);
    cyc();
    check("sat_hold", 32'(err_cnt_o), 255);
    clr_cnt_i = 1'b1;
    cyc();
    check("clr_cnt", 32'(err_cnt_o), 0);
    clr_cnt_i = 1'b0;
    cyc();
    check("post_clr_cnt", 32'(err_cnt_o), 1);
    valid_i = 1'b0;
    cyc();

    // 5. Asynchronous reset while a word is held
    one_hot_i = 16'h0080;
    valid_i   = 1'b1;
    ready_i   = 1'b0;
    cyc();
    check("pre_rst_valid", 32'(valid_o), 1);
    check("pre_rst_bin", 32'(bin_o), 7);
    valid_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", 32'(valid_o), 0);
    check("async_bin", 32'(bin_o), 0);
    check("async_cnt", 32'(err_cnt_o), 0);
    check("async_ready", 32'(ready_o), 1);
    #2;
    reset_n   = 1'b1;
    ready_i   = 1'b1;
    one_hot_i = 16'h0004;
    valid_i   = 1'b1;
    cyc();
    check("post_rst_bin", 32'(bin_o), 2);
    check("post_rst_err", 32'(err_o), 0);
    check("post_rst_valid", 32'(valid_o), 1);

    // 6. Random indices through the encoder model
    for (int i = 0; i < 32; i++) begin
      idx       = $urandom_range(0, 15);
      one_hot_i = bin2oh(idx);
      cyc();
      check("enc_bin", 32'(bin_o), 32'(idx));
      check("enc_err", 32'(err_o), 0);
    end
    valid_i = 1'b0;
    cyc();
    check("final_cnt", 32'(err_cnt_o), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/one_hot_dec.md
Name: one_hot_dec

Overview:
Streaming one-hot to binary decoder, the inverse of the existing binary to one-hot encoder. It accepts one-hot words on a valid/ready input, checks that exactly one bit is set, and returns the bit index on a registered valid/ready output with an error flag. A saturating error counter tracks malformed words for debug. It sits downstream of one-hot producers (arbiter grants, encoder outputs) and feeds binary consumers.

Parameters:
BIN_W, 4, width of binary output index
ONE_HOT_W, 16, width of one-hot input; must equal 2**BIN_W (elaboration-time assertion)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
one_hot_i  input  ONE_HOT_W  one-hot word to decode
valid_i  input  1  one_hot_i is valid this cycle
ready_o  output  1  block can accept one_hot_i this cycle
bin_o  output  BIN_W  decoded index
err_o  output  1  word held in bin_o was not exactly one-hot
valid_o  output  1  bin_o/err_o are valid
ready_i  input  1  downstream accepts bin_o this cycle
err_cnt_o  output  ERR_CNT_W  count of accepted malformed words, saturating
clr_cnt_i  input  1  synchronous clear of err_cnt_o

Behaviour:
- Reset (reset_n low, asynchronous assert): valid_o=0, bin_o=0, err_o=0, err_cnt_o=0. ready_o is 1 while in reset and after release, because it is derived from valid_o.
- Input handshake: accept when valid_i && ready_o.
- ready_o = !valid_o || ready_i (combinational). Single output register with full throughput; one word per cycle when ready_i is held high.
- Output handshake: transfer when valid_o && ready_i. Once raised, valid_o holds high, and bin_o/err_o hold stable, until the transfer.
- Latency: word accepted in cycle N appears on bin_o/valid_o in cycle N+1.
- States: EMPTY (valid_o=0) and FULL (valid_o=1).
  - EMPTY to FULL on accept.
  - FULL to FULL on simultaneous accept and transfer; the new word replaces the old.
  - FULL to EMPTY on transfer without accept.
  - FULL holds with no transfer.
- Decode rules, evaluated on the accepted word:
  - Exactly one bit k set: bin_o=k, err_o=0.
  - Zero bits set: bin_o=0, err_o=1.
  - Two or more bits set: bin_o = index of the lowest set bit, err_o=1.
- Width rules: bin_o is BIN_W bits, and index ONE_HOT_W-1 maps to all-ones. Popcount needs only "zero / one / more than one" detection; no full adder tree.
- Error counter:
  - Increments by 1 on each accepted word with err=1.
  - Saturates at 2**ERR_CNT_W-1 and does not wrap.
  - clr_cnt_i=1 forces 0 next cycle and takes priority over a simultaneous increment.
- valid_i=0: no state change regardless of one_hot_i contents (X/garbage is ignored).
- Reset mid-transfer: any held word is discarded immediately, valid_o drops asynchronously, and the counter clears.

Decomposition:
- Package one_hot_pkg: defaults BIN_W=4, ONE_HOT_W=16, ERR_CNT_W=8; function lowest_set_idx(); function onehot_class() returning enum {OH_ZERO, OH_ONE, OH_MULTI}.
- Sub-module one_hot_chk: purely combinational. Takes the one-hot word; outputs index (lowest set bit) and err. Instantiated once in front of the output register so the checker can be reused by other blocks.

Test Plan:
1. Reset then exhaustive legal: one_hot_i=16'h0001 to 16'h8000 (1<<k), valid_i=1, ready_i=1 every cycle -> bin_o=k and err_o=0 one cycle later, valid_o high continuously, err_cnt_o stays 0.
2. Malformed: one_hot_i=16'h0000 -> bin_o=0, err_o=1; one_hot_i=16'h0A00 -> bin_o=9, err_o=1; err_cnt_o=2 afterwards.
3. Backpressure: send 16'h0010 with ready_i=0 for 3 cycles -> valid_o=1, bin_o=4 held stable and ready_o=0 throughout; assert ready_i -> transfer; next word 16'h0100 -> bin_o=8.
4. Saturation and clear:
   - 300 accepted 16'h0003 words -> err_cnt_o=255 and holds.
   - clr_cnt_i=1 together with an erroneous accept -> err_cnt_o=0 next cycle.
5. Async reset mid-operation: reset_n low between clock edges while valid_o=1 (bin_o=7) -> valid_o, bin_o and err_cnt_o go to 0 before the next edge; first word after release, 16'h0004, decodes to bin_o=2.
6. Randomized: 32 random 4-bit indices through the existing binary to one-hot encoder into this block -> bin_o equals the original index, err_o=0 for all 32.
